// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, alignment FSM states and
// the data-word decode function.
package tmds_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SLIP   = 2'd1,
        SETTLE = 2'd2,
        LOCKED = 2'd3
    } tmds_align_state_t;

    // q[9] undoes the DC-balance inversion; q[8] selects XOR or XNOR chaining.
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
        logic [7:0] t;
        logic [7:0] d;
        t    = q[9] ? ~q[7:0] : q[7:0];
        d    = '0;
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_token_detect.sv
// Combinational recogniser for the four TMDS control tokens; also used by the
// lane-skew logic in hdmi_rx.
module tmds_token_detect
    import tmds_pkg::*;
(
    input  logic [9:0] word_i,
    output logic       is_ctrl_o,
    output logic [1:0] ctrl_o
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        is_ctrl_o = 1'b1;
        ctrl_o    = 2'b00;
        case (word_i)
            TOKEN_C00: ctrl_o = 2'b00;
            TOKEN_C01: ctrl_o = 2'b01;
            TOKEN_C10: ctrl_o = 2'b10;
            TOKEN_C11: ctrl_o = 2'b11;
            default:   is_ctrl_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: hunts for word alignment with bitslip requests, then
// decodes aligned words to pixel data or control bits with one cycle latency.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN     = 8,
    parameter int SLIP_SETTLE  = 4,
    parameter int HUNT_TIMEOUT = 4096,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       rx_clk,
    input  logic       rstn,
    input  logic [9:0] tmds_word_i,
    output logic       bitslip_o,
    output logic       aligned_o,
    output logic       de_o,
    output logic [7:0] data_o,
    output logic [1:0] ctrl_o,
    output logic [3:0] slip_cnt_o
);

    localparam int TMO_MAX = (HUNT_TIMEOUT > LOCK_TIMEOUT) ? HUNT_TIMEOUT : LOCK_TIMEOUT;
    localparam int RUN_W   = $clog2(CTRL_RUN) + 1;
    localparam int TMO_W   = $clog2(TMO_MAX) + 1;
    localparam int SET_W   = $clog2(SLIP_SETTLE) + 1;

    localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(CTRL_RUN);
    localparam logic [TMO_W-1:0] HUNT_LAST   = TMO_W'(HUNT_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] LOCK_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SLIP_SETTLE - 1);

    tmds_align_state_t state_q, state_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [1:0]        last_ctrl_q, last_ctrl_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [3:0]        slip_cnt_q, slip_cnt_d;
    logic              aligned_q, aligned_d;
    logic              bitslip_q, bitslip_d;
    logic              de_q, de_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        ctrl_q, ctrl_d;

    logic              is_ctrl;
    logic [1:0]        tok_ctrl;

    tmds_token_detect u_token_detect (
        .word_i    (tmds_word_i),
        .is_ctrl_o (is_ctrl),
        .ctrl_o    (tok_ctrl)
    );

    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        settle_cnt_d = settle_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        last_ctrl_d  = last_ctrl_q;
        run_cnt_d    = '0;

        if (is_ctrl) begin
            last_ctrl_d = tok_ctrl;
            if ((run_cnt_q != '0) && (tok_ctrl == last_ctrl_q)) begin
                run_cnt_d = (run_cnt_q == RUN_FULL) ? RUN_FULL : run_cnt_q + 1'b1;
            end else begin
                run_cnt_d = RUN_W'(1);
            end
        end

        case (state_q)
            HUNT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A completed run takes priority over an expiring hunt timer.
                if (run_cnt_q == RUN_FULL) begin
                    state_d   = LOCKED;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == HUNT_LAST) begin
                    state_d   = SLIP;
                    tmo_cnt_d = '0;
                end
            end
            SLIP: begin
                state_d      = SETTLE;
                settle_cnt_d = '0;
                run_cnt_d    = '0;
                slip_cnt_d   = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
            end
            SETTLE: begin
                run_cnt_d = '0;
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = HUNT;
                    settle_cnt_d = '0;
                    tmo_cnt_d    = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            LOCKED: begin
                if (is_ctrl) begin
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == LOCK_LAST) begin
                    state_d    = HUNT;
                    tmo_cnt_d  = '0;
                    slip_cnt_d = 4'd0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        // Outputs follow the next state so they are never non-zero while unlocked.
        aligned_d = (state_d == LOCKED);
        bitslip_d = (state_d == SLIP);
        de_d      = aligned_d && !is_ctrl;
        data_d    = (aligned_d && !is_ctrl) ? tmds_decode_data(tmds_word_i) : 8'h00;
        ctrl_d    = (aligned_d && is_ctrl) ? tok_ctrl : 2'b00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge rx_clk) begin
        if (!rstn) begin
            state_q      <= HUNT;
            run_cnt_q    <= '0;
            last_ctrl_q  <= 2'b00;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
            slip_cnt_q   <= 4'd0;
            aligned_q    <= 1'b0;
            bitslip_q    <= 1'b0;
            de_q         <= 1'b0;
            data_q       <= 8'h00;
            ctrl_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            last_ctrl_q  <= last_ctrl_d;
            tmo_cnt_q    <= tmo_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            aligned_q    <= aligned_d;
            bitslip_q    <= bitslip_d;
            de_q         <= de_d;
            data_q       <= data_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign bitslip_o  = bitslip_q;
    assign aligned_o  = aligned_q;
    assign de_o       = de_q;
    assign data_o     = data_q;
    assign ctrl_o     = ctrl_q;
    assign slip_cnt_o = slip_cnt_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: the driver pushes expectations per
// word, a monitor pops and compares them after every rising edge.
module tb_tmds_channel_decoder;

    localparam int HUNT_T   = 64;
    localparam int LOCK_T   = 256;
    localparam int SETTLE_T = 4;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    // Neither word is a token under any rotation (popcount 1 and 9).
    localparam logic [9:0] W_A = 10'b0100000000;  // decodes to 8'h00
    localparam logic [9:0] W_B = 10'b1011111111;  // decodes to 8'hFE

    logic       rx_clk = 1'b0;
    logic       rstn = 1'b0;
    logic [9:0] tmds_word_i = '0;
    logic       bitslip_o;
    logic       aligned_o;
    logic       de_o;
    logic [7:0] data_o;
    logic [1:0] ctrl_o;
    logic [3:0] slip_cnt_o;

    tmds_channel_decoder #(
        .CTRL_RUN     (8),
        .SLIP_SETTLE  (SETTLE_T),
        .HUNT_TIMEOUT (HUNT_T),
        .LOCK_TIMEOUT (LOCK_T)
    ) dut (
        .rx_clk      (rx_clk),
        .rstn        (rstn),
        .tmds_word_i (tmds_word_i),
        .bitslip_o   (bitslip_o),
        .aligned_o   (aligned_o),
        .de_o        (de_o),
        .data_o      (data_o),
        .ctrl_o      (ctrl_o),
        .slip_cnt_o  (slip_cnt_o)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        string    tag;
        bit       c_out;
        bit       all;
        bit       de;
        bit [7:0] data;
        bit [1:0] ctrl;
        bit       c_al;
        bit       al;
        bit       c_sc;
        bit [3:0] sc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   last_pulse = -100;
    int   base_off = 0;
    int   pulse_base = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input string tag, input bit c_out, input bit de,
                                input bit [7:0] data, input bit [1:0] ctrl, input bit c_al,
                                input bit al, input bit c_sc, input bit [3:0] sc);
        exp_t e;
        e.tag = tag; e.c_out = c_out; e.all = 1'b0; e.de = de; e.data = data; e.ctrl = ctrl;
        e.c_al = c_al; e.al = al; e.c_sc = c_sc; e.sc = sc;
        return e;
    endfunction

    // Unlocked lane: every output is zero.
    function automatic exp_t e_zero(input string tag, input bit c_sc);
        exp_t e;
        e = mk(tag, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, c_sc, 4'd0);
        e.all = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_none();
        return mk("none", 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    endfunction

    // Deserializer model: word boundary offset, shifted by one per bitslip pulse.
    function automatic logic [9:0] rot(input logic [9:0] w, input int r);
        logic [19:0] x;
        x = {w, w} >> r;
        return x[9:0];
    endfunction

    task automatic drive(input logic run, input logic [9:0] w, input exp_t e);
        int r;
        @(negedge rx_clk);
        r = ((base_off - (pulses - pulse_base)) % 10 + 10) % 10;
        rstn = run;
        tmds_word_i = rot(w, r);
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge rx_clk);
            #1;
            cyc++;
            if (bitslip_o === 1'b1) begin
                if (pulses > 0) check("slip_spacing", int'((cyc - last_pulse) >= SETTLE_T + 1), 1);
                pulses++;
                last_pulse = cyc;
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.c_out) begin
                    check({e.tag, "/de_o"}, int'(de_o), int'(e.de));
                    if (e.de || e.all) check({e.tag, "/data_o"}, int'(data_o), int'(e.data));
                    if (!e.de || e.all) check({e.tag, "/ctrl_o"}, int'(ctrl_o), int'(e.ctrl));
                end
                if (e.c_al) check({e.tag, "/aligned_o"}, int'(aligned_o), int'(e.al));
                if (e.c_sc) begin
                    check({e.tag, "/slip_cnt_o"}, int'(slip_cnt_o), int'(e.sc));
                    check({e.tag, "/bitslip_o"}, int'(bitslip_o), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [9:0] dv_w [6];
        logic [7:0] dv_b [6];
        logic [9:0] tk_w [4];
        logic [1:0] tk_c [4];
        exp_t       e;
        logic [9:0] w;
        bit         tok;
        bit         got;

        // Expected bytes worked out by hand from the decode equations.
        dv_w[0] = 10'b0100000000; dv_b[0] = 8'h00;
        dv_w[1] = 10'b1011111111; dv_b[1] = 8'hFE;
        dv_w[2] = 10'b1000000000; dv_b[2] = 8'hFF;
        dv_w[3] = 10'b0001010101; dv_b[3] = 8'h01;
        dv_w[4] = 10'b0110101010; dv_b[4] = 8'hFE;
        dv_w[5] = 10'b1100001111; dv_b[5] = 8'h10;
        tk_w[0] = T01; tk_c[0] = 2'b01;
        tk_w[1] = T10; tk_c[1] = 2'b10;
        tk_w[2] = T11; tk_c[2] = 2'b11;
        tk_w[3] = T00; tk_c[3] = 2'b00;

        // Reset, then an aligned blanking run followed by data and all tokens.
        repeat (2) drive(1'b0, T00, e_zero("reset", 1'b1));
        for (int i = 1; i <= 20; i++) begin
            if (i <= 7)      e = e_zero("a_hunt", 1'b1);
            else if (i <= 9) e = mk("a_lock", 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0);
            else             e = mk("a_tok", 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 4'd0);
            drive(1'b1, T00, e);
        end
        for (int i = 0; i < 6; i++)
            drive(1'b1, dv_w[i], mk("a_data", 1'b1, 1'b1, dv_b[i], 2'b00, 1'b1, 1'b1, 1'b1, 4'd0));
        for (int i = 0; i < 4; i++)
            drive(1'b1, tk_w[i], mk("a_ctrl", 1'b1, 1'b0, 8'h00, tk_c[i], 1'b1, 1'b1, 1'b1, 4'd0));
        check("a_no_slip", pulses - pulse_base, 0);

        // Stream misaligned by 3 bits; blanking occupies positions 19..50 of each 100.
        base_off = 3;
        pulse_base = pulses;
        repeat (2) drive(1'b0, W_A, e_zero("c_reset", 1'b1));
        for (int p = 0; p < 400; p++) begin
            tok = ((p % 100) >= 19) && ((p % 100) < 51);
            w = tok ? T00 : (((p % 2) == 0) ? W_A : W_B);
            if (p + 1 <= 219) e = e_zero("c_hunt", 1'b0);
            else if (p + 1 < 240) e = e_none();
            else if (tok) e = mk("c_tok", 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 4'd3);
            else e = mk("c_data", 1'b1, 1'b1, ((p % 2) == 0) ? 8'h00 : 8'hFE, 2'b00,
                        1'b1, 1'b1, 1'b1, 4'd3);
            drive(1'b1, w, e);
        end
        check("c_slips", pulses - pulse_base, 3);

        // Data only after one token: lock drops on the 256th data word.
        drive(1'b1, T00, mk("b_tok", 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 4'd3));
        for (int j = 1; j <= 256; j++) begin
            if (j < 256) e = mk("b_data", 1'b1, 1'b1, ((j % 2) == 1) ? 8'h00 : 8'hFE, 2'b00,
                                1'b1, 1'b1, 1'b1, 4'd3);
            else         e = e_zero("b_drop", 1'b1);
            drive(1'b1, ((j % 2) == 1) ? W_A : W_B, e);
        end
        repeat (3) drive(1'b1, W_A, e_zero("b_rehunt", 1'b1));

        // Reset asserted for one cycle while settling after a bitslip.
        base_off = 1;
        pulse_base = pulses;
        repeat (2) drive(1'b0, W_A, e_zero("d_reset", 1'b1));
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            drive(1'b1, ((i % 2) == 0) ? W_A : W_B, e_none());
            if (pulses - pulse_base == 1) got = 1'b1;
        end
        check("d_slip_seen", int'(got), 1);
        repeat (2) drive(1'b1, W_A, e_none());
        drive(1'b0, W_A, e_zero("d_rst_settle", 1'b1));
        for (int i = 1; i <= 20; i++) begin
            if (i <= 7)      e = e_zero("d_hunt", 1'b1);
            else if (i <= 9) e = e_none();
            else             e = mk("d_relock", 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 4'd0);
            drive(1'b1, T00, e);
        end
        check("d_slips", pulses - pulse_base, 1);

        // Run completes exactly when the hunt timer would expire: lock wins.
        base_off = 0;
        pulse_base = pulses;
        repeat (2) drive(1'b0, W_A, e_zero("e_reset", 1'b1));
        for (int n = 1; n <= 55; n++)
            drive(1'b1, ((n % 2) == 1) ? W_A : W_B, e_zero("e_hunt", 1'b1));
        for (int n = 56; n <= 75; n++) begin
            if (n <= 62)      e = e_zero("e_run", 1'b1);
            else if (n <= 65) e = mk("e_edge", 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0);
            else              e = mk("e_lock", 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 4'd0);
            drive(1'b1, T00, e);
        end
        repeat (3) @(posedge rx_clk);
        #2;
        check("e_no_slip", pulses - pulse_base, 0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
